// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one line-wide memory port between the
//            instruction cache (client 0) and the data cache (client 1).
//            Holds the grant for a whole transaction, routes read data back
//            to the owner and aborts a read whose response never arrives.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int LINE_WIDTH = 128,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    // client 0 (instruction cache)
    input  logic [ADDR_WIDTH-1:0] i_c0_addr,
    input  logic                  i_c0_read,
    input  logic                  i_c0_write,
    input  logic [LINE_WIDTH-1:0] i_c0_writedata,
    output logic [LINE_WIDTH-1:0] o_c0_readdata,
    output logic                  o_c0_readdata_valid,
    output logic                  o_c0_waitrequest,
    // client 1 (data cache)
    input  logic [ADDR_WIDTH-1:0] i_c1_addr,
    input  logic                  i_c1_read,
    input  logic                  i_c1_write,
    input  logic [LINE_WIDTH-1:0] i_c1_writedata,
    output logic [LINE_WIDTH-1:0] o_c1_readdata,
    output logic                  o_c1_readdata_valid,
    output logic                  o_c1_waitrequest,
    // memory port
    output logic [ADDR_WIDTH-1:0] o_m_addr,
    output logic                  o_m_read,
    output logic                  o_m_write,
    output logic [LINE_WIDTH-1:0] o_m_writedata,
    input  logic [LINE_WIDTH-1:0] i_m_readdata,
    input  logic                  i_m_readdata_valid,
    input  logic                  i_m_waitrequest,
    // status
    output logic [1:0]            o_grant,
    output logic                  o_timeout,
    output logic                  o_err
);

    localparam int                c_TIMER_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CMD  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 owner_q, owner_d;   // 0 = client 0, 1 = client 1
    logic                 last_q,  last_d;    // owner of the previous grant
    logic [c_TIMER_W-1:0] timer_q, timer_d;
    logic                 err_q,   err_d;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_own_read;
    logic                  w_own_write;
    logic [ADDR_WIDTH-1:0] w_own_addr;
    logic [LINE_WIDTH-1:0] w_own_wdata;
    logic                  w_accept;
    logic                  w_expire;

    assign w_req0 = i_c0_read | i_c0_write;
    assign w_req1 = i_c1_read | i_c1_write;

    // Owner's command view; read wins when a client raises both strobes.
    assign w_own_read  = owner_q ? i_c1_read : i_c0_read;
    assign w_own_write = (owner_q ? i_c1_write : i_c0_write) & ~w_own_read;
    assign w_own_addr  = owner_q ? i_c1_addr : i_c0_addr;
    assign w_own_wdata = owner_q ? i_c1_writedata : i_c0_writedata;

    assign w_accept = (w_own_read | w_own_write) & ~i_m_waitrequest;
    // Last RESP cycle allowed: the timer has already counted TIMEOUT-1 cycles.
    assign w_expire = (timer_q == c_TIMER_LAST);

    // Read data bus is shared; only the valid strobe is steered.
    assign o_c0_readdata = i_m_readdata;
    assign o_c1_readdata = i_m_readdata;
    assign o_err         = err_q;

    // State register and arbitration bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: round-robin grant, command completion, response wait.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        timer_d = timer_q;
        err_d   = err_q;
        case (state_q)
            c_IDLE: begin
                if (w_req0 | w_req1) begin
                    // On a tie the client that did not own the port last wins.
                    owner_d = (w_req0 & w_req1) ? ~last_q : w_req1;
                    last_d  = owner_d;
                    timer_d = '0;
                    state_d = c_CMD;
                end
            end
            c_CMD: begin
                if (!(w_own_read | w_own_write)) begin
                    // Owner withdrew before acceptance: abandon quietly.
                    state_d = c_IDLE;
                end else if (!i_m_waitrequest) begin
                    state_d = w_own_read ? c_RESP : c_IDLE;
                end
            end
            c_RESP: begin
                if (i_m_readdata_valid) begin
                    state_d = c_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (w_expire) begin
                        state_d = c_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = c_IDLE;
        endcase
        // Read data with no read outstanding is a memory-side protocol error.
        if (i_m_readdata_valid && (state_q != c_RESP)) begin
            err_d = 1'b1;
        end
    end

    // Output decode: memory command from the owner, strobes back to the owner.
    always_comb begin
        o_m_addr            = '0;
        o_m_writedata       = '0;
        o_m_read            = 1'b0;
        o_m_write           = 1'b0;
        o_c0_waitrequest    = 1'b1;
        o_c1_waitrequest    = 1'b1;
        o_c0_readdata_valid = 1'b0;
        o_c1_readdata_valid = 1'b0;
        o_grant             = 2'b00;
        o_timeout           = 1'b0;
        case (state_q)
            c_CMD: begin
                o_m_addr      = w_own_addr;
                o_m_writedata = w_own_wdata;
                o_m_read      = w_own_read;
                o_m_write     = w_own_write;
                o_grant       = owner_q ? 2'b10 : 2'b01;
                if (owner_q) begin
                    o_c1_waitrequest = ~w_accept;
                end else begin
                    o_c0_waitrequest = ~w_accept;
                end
            end
            c_RESP: begin
                o_grant = owner_q ? 2'b10 : 2'b01;
                if (owner_q) begin
                    o_c1_readdata_valid = i_m_readdata_valid;
                end else begin
                    o_c0_readdata_valid = i_m_readdata_valid;
                end
                o_timeout = ~i_m_readdata_valid & w_expire;
            end
            default: begin
                o_grant = 2'b00;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Randomized scoreboard bench for mem_port_arbiter: client agents
//            and a memory responder generate traffic, a monitor compares the
//            DUT outputs against transaction-level expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 20;
    localparam int LW = 128;
    localparam int TO = 255;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] c0_addr = '0, c1_addr = '0;
    logic          c0_rd = 1'b0, c0_wr = 1'b0, c1_rd = 1'b0, c1_wr = 1'b0;
    logic [LW-1:0] c0_wd = '0, c1_wd = '0;
    logic [LW-1:0] m_rdata = '0;
    logic          m_rdv = 1'b0, m_wait = 1'b0;
    logic          stray_now = 1'b0;

    logic [LW-1:0] o_c0_readdata, o_c1_readdata, o_m_writedata;
    logic          o_c0_readdata_valid, o_c1_readdata_valid;
    logic          o_c0_waitrequest, o_c1_waitrequest;
    logic [AW-1:0] o_m_addr;
    logic          o_m_read, o_m_write, o_timeout, o_err;
    logic [1:0]    o_grant;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_c0_addr(c0_addr), .i_c0_read(c0_rd), .i_c0_write(c0_wr), .i_c0_writedata(c0_wd),
        .o_c0_readdata(o_c0_readdata), .o_c0_readdata_valid(o_c0_readdata_valid),
        .o_c0_waitrequest(o_c0_waitrequest),
        .i_c1_addr(c1_addr), .i_c1_read(c1_rd), .i_c1_write(c1_wr), .i_c1_writedata(c1_wd),
        .o_c1_readdata(o_c1_readdata), .o_c1_readdata_valid(o_c1_readdata_valid),
        .o_c1_waitrequest(o_c1_waitrequest),
        .o_m_addr(o_m_addr), .o_m_read(o_m_read), .o_m_write(o_m_write),
        .o_m_writedata(o_m_writedata), .i_m_readdata(m_rdata),
        .i_m_readdata_valid(m_rdv), .i_m_waitrequest(m_wait),
        .o_grant(o_grant), .o_timeout(o_timeout), .o_err(o_err)
    );

    // Scoreboard state
    cmd_t          cmd_q0[$], cmd_q1[$];
    logic [LW-1:0] rsp_q0[$], rsp_q1[$];
    int            to_q[$];
    int            checks = 0, errors = 0;
    int            cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state kept by the monitor
    logic [1:0] prev_g = 2'b00;
    logic prev_r0 = 1'b0, prev_r1 = 1'b0, rst_seen = 1'b1, last_m = 1'b1, exp_err = 1'b0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] d);
        cmd_t c;
        c.rd = rd; c.addr = a; c.data = d;
        if (n == 0) begin
            c0_rd = rd; c0_wr = wr; c0_addr = a; c0_wd = d; cmd_q0.push_back(c);
        end else begin
            c1_rd = rd; c1_wr = wr; c1_addr = a; c1_wd = d; cmd_q1.push_back(c);
        end
    endtask

    task automatic release_client(input int n);
        if (n == 0) begin c0_rd = 1'b0; c0_wr = 1'b0; end
        else        begin c1_rd = 1'b0; c1_wr = 1'b0; end
    endtask

    task automatic new_txn(input int n);
        int r;
        r = $urandom % 8;
        if (r == 0)     issue(n, 1'b1, 1'b1, AW'($urandom), rand_line());
        else if (r < 5) issue(n, 1'b1, 1'b0, AW'($urandom), rand_line());
        else            issue(n, 1'b0, 1'b1, AW'($urandom), rand_line());
    endtask

    // Waits (bounded) for client n to see its command accepted, then drops it.
    task automatic wait_accept(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((n == 0 && !o_c0_waitrequest) || (n == 1 && !o_c1_waitrequest)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("accept_in_budget", ok, 1'b1);
        tick();
        release_client(n);
    endtask

    task automatic cmp_cmd(input int n, input cmd_t c);
        check("m_op", {o_m_read, o_m_write}, c.rd ? 2'b10 : 2'b01);
        check("m_addr", o_m_addr, c.addr);
        check("m_wdata", o_m_writedata, c.data);
        check("grant_at_accept", o_grant, (n == 0) ? 2'b01 : 2'b10);
    endtask

    // One monitor step: compares every DUT output group with the model.
    task automatic mon_cycle();
        logic [1:0]    exp_g;
        logic          to_now;
        logic [LW-1:0] d;
        cmd_t          c;
        int            n;
        if (rst_seen) begin
            check("rst_grant", o_grant, 2'b00);
            check("rst_mcmd", {o_m_read, o_m_write}, 2'b00);
            check("rst_maddr", o_m_addr, '0);
            check("rst_mwdata", o_m_writedata, '0);
            last_m = 1'b1;
        end else if (prev_g == 2'b00) begin
            if (prev_r0 && prev_r1) exp_g = last_m ? 2'b01 : 2'b10;
            else if (prev_r0)       exp_g = 2'b01;
            else if (prev_r1)       exp_g = 2'b10;
            else                    exp_g = 2'b00;
            check("grant_pick", o_grant, exp_g);
            if (exp_g != 2'b00) last_m = exp_g[1];
        end else if (o_grant != 2'b00) begin
            check("grant_hold", o_grant, prev_g);
        end

        if ((o_m_read || o_m_write) && !m_wait) begin
            n = -1;
            if (!o_c0_waitrequest && o_c1_waitrequest)      n = 0;
            else if (o_c0_waitrequest && !o_c1_waitrequest) n = 1;
            check("accept_one_owner", (n >= 0), 1'b1);
            if (n == 0 && cmd_q0.size() > 0) begin
                c = cmd_q0.pop_front(); cmp_cmd(0, c);
            end else if (n == 1 && cmd_q1.size() > 0) begin
                c = cmd_q1.pop_front(); cmp_cmd(1, c);
            end else if (n >= 0) begin
                check("accept_unexpected", 1'b1, 1'b0);
            end
        end else begin
            check("waitreq_idle", {o_c0_waitrequest, o_c1_waitrequest}, 2'b11);
        end

        if (o_c0_readdata_valid) begin
            if (rsp_q0.size() == 0) check("c0_rdv_unexpected", 1'b1, 1'b0);
            else begin d = rsp_q0.pop_front(); check("c0_rdata", o_c0_readdata, d); end
        end
        if (o_c1_readdata_valid) begin
            if (rsp_q1.size() == 0) check("c1_rdv_unexpected", 1'b1, 1'b0);
            else begin d = rsp_q1.pop_front(); check("c1_rdata", o_c1_readdata, d); end
        end

        to_now = (to_q.size() > 0) && (to_q[0] == cyc);
        check("timeout", o_timeout, to_now);
        if (to_now) void'(to_q.pop_front());
        check("err", o_err, exp_err);
        exp_err = rst ? 1'b0 : (exp_err | to_now | stray_now);

        prev_g   = o_grant;
        prev_r0  = c0_rd | c0_wr;
        prev_r1  = c1_rd | c1_wr;
        rst_seen = rst;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            mon_cycle();
        end
    end

    // Stimulus: random traffic phase, then directed scenarios.
    initial begin : driver
        bit busy0, busy1, acc0, acc1, pend, a0, a1;
        int gap0, gap1, left0, left1, plat, pcli, guard;
        bit ord[$];
        busy0 = 0; busy1 = 0; pend = 0; gap0 = 0; gap1 = 0;
        left0 = 25; left1 = 25; plat = 0; pcli = 0; guard = 0;

        repeat (3) tick();
        rst = 1'b0;

        // ---- random traffic with random memory stalls, latency and drops ----
        while (!(left0 == 0 && left1 == 0 && !busy0 && !busy1 && !pend &&
                 to_q.size() == 0 && rsp_q0.size() == 0 && rsp_q1.size() == 0)) begin
            guard++;
            if (guard > 20000) begin
                check("random_phase_budget", 1'b0, 1'b1);
                break;
            end
            @(negedge clk);
            acc0 = busy0 && !o_c0_waitrequest;
            acc1 = busy1 && !o_c1_waitrequest;
            if ((acc0 && c0_rd) || (acc1 && c1_rd)) begin
                pend = 1'b1;
                pcli = acc0 ? 0 : 1;
                plat = $urandom % 6;
                if ($urandom % 6 == 0) begin
                    to_q.push_back(cyc + TO);
                    pend = 1'b0;
                end
            end
            tick();
            m_rdv   = 1'b0;
            m_rdata = rand_line();
            if (pend) begin
                if (plat == 0) begin
                    m_rdv = 1'b1;
                    if (pcli == 0) rsp_q0.push_back(m_rdata);
                    else           rsp_q1.push_back(m_rdata);
                    pend = 1'b0;
                end else begin
                    plat--;
                end
            end
            m_wait = ($urandom % 3 == 0);
            if (acc0) begin
                release_client(0); busy0 = 0; gap0 = $urandom % 4;
            end else if (!busy0) begin
                if (gap0 > 0) gap0--;
                else if (left0 > 0) begin new_txn(0); busy0 = 1; left0--; end
            end
            if (acc1) begin
                release_client(1); busy1 = 0; gap1 = $urandom % 4;
            end else if (!busy1) begin
                if (gap1 > 0) gap1--;
                else if (left1 > 0) begin new_txn(1); busy1 = 1; left1--; end
            end
        end
        m_rdv = 1'b0; m_wait = 1'b0;
        repeat (3) tick();

        // ---- single c0 read, memory stalls two CMD cycles, data 0xA5.. ----
        issue(0, 1'b1, 1'b0, 20'h00100, '0);
        m_wait = 1'b1;
        repeat (3) tick();
        m_wait = 1'b0;
        wait_accept(0);
        repeat (2) tick();
        m_rdata = {16{8'hA5}};
        m_rdv   = 1'b1;
        rsp_q0.push_back(m_rdata);
        tick();
        m_rdv = 1'b0;
        repeat (2) tick();

        // ---- both clients request continuously from reset: c0,c1,c0,... ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(0, 1'b1, 1'b0, AW'($urandom), rand_line());
        issue(1, 1'b0, 1'b1, AW'($urandom), rand_line());
        guard = 0;
        while (ord.size() < 6 && guard < 100) begin
            guard++;
            @(negedge clk);
            a0 = !o_c0_waitrequest;
            a1 = !o_c1_waitrequest;
            if (a0) ord.push_back(1'b0);
            if (a1) ord.push_back(1'b1);
            tick();
            m_rdv = 1'b0;
            if (a0) begin
                m_rdata = rand_line();
                m_rdv   = 1'b1;
                rsp_q0.push_back(m_rdata);
                issue(0, 1'b1, 1'b0, AW'($urandom), rand_line());
            end
            if (a1) issue(1, 1'b0, 1'b1, AW'($urandom), rand_line());
        end
        release_client(0);
        release_client(1);
        if (cmd_q0.size() > 0) void'(cmd_q0.pop_back());
        if (cmd_q1.size() > 0) void'(cmd_q1.pop_back());
        check("rr_count", ord.size(), 6);
        for (int i = 0; i < ord.size() && i < 6; i++) check("rr_order", ord[i], i % 2);
        tick();
        m_rdv = 1'b0;
        repeat (2) tick();

        // ---- c1 abandons its read under stall, pending c0 write served ----
        m_wait = 1'b1;
        issue(1, 1'b1, 1'b0, 20'h2BEEF, rand_line());
        tick();
        issue(0, 1'b0, 1'b1, 20'h0CAFE, rand_line());
        repeat (2) tick();
        release_client(1);
        void'(cmd_q1.pop_back());
        tick();
        m_wait = 1'b0;
        wait_accept(0);
        tick();
        @(negedge clk);
        check("abandon_no_err", o_err, 1'b0);
        tick();

        // ---- reset during RESP, then a stray response ----
        issue(0, 1'b1, 1'b0, 20'h0ABCD, rand_line());
        wait_accept(0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        m_rdata   = rand_line();
        m_rdv     = 1'b1;
        stray_now = 1'b1;
        tick();
        m_rdv     = 1'b0;
        stray_now = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("stray_sets_err", o_err, 1'b1);
        check("stray_grant_idle", o_grant, 2'b00);
        repeat (3) tick();

        check("cmd_q0_drained", cmd_q0.size(), 0);
        check("cmd_q1_drained", cmd_q1.size(), 0);
        check("rsp_q0_drained", rsp_q0.size(), 0);
        check("rsp_q1_drained", rsp_q1.size(), 0);
        check("timeouts_drained", to_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
